// File: rtl/jerry_pkg.sv
// Shared definitions for the Jerry-side bus requester: FSM state codes,
// transfer-source encodings and default timing parameters.
package jerry_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    localparam logic SEL_DSP = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    localparam int unsigned HOLD_MAX_DEF = 8;
    localparam int unsigned REL_GAP_DEF  = 2;
    localparam int unsigned WDOG_DEF     = 1023;

endpackage

// File: rtl/busreq_prio.sv
// Request merge: DMA-over-DSP source select, urgency term and any-pending flag.
module busreq_prio
    import jerry_pkg::*;
(
    input  logic dsp_req,
    input  logic dsp_hipri,
    input  logic dma_req,
    output logic pending_c,
    output logic urgent_c,
    output logic sel_c
);

    always_comb begin
        pending_c = dsp_req | dma_req;
        urgent_c  = dma_req | (dsp_req & dsp_hipri);
        sel_c     = dma_req ? SEL_DMA : SEL_DSP;
    end

endmodule

// File: rtl/jerry_busreq.sv
// Jerry bus requester: drives the active-low request pair, waits for grant,
// sequences one-at-a-time transfers during a tenure and releases the bus.
module jerry_busreq #(
    parameter int unsigned HOLD_MAX = jerry_pkg::HOLD_MAX_DEF,
    parameter int unsigned REL_GAP  = jerry_pkg::REL_GAP_DEF,
    parameter int unsigned WDOG     = jerry_pkg::WDOG_DEF
) (
    input  logic sys_clk,
    input  logic resetl,
    input  logic dsp_req,
    input  logic dsp_hipri,
    input  logic dma_req,
    input  logic dbgl,
    input  logic ack,
    output logic dbrl_0,
    output logic dbrl_1,
    output logic bus_own,
    output logic xfer_go,
    output logic xfer_sel,
    output logic dsp_done,
    output logic dma_done,
    output logic wd_err
);
    import jerry_pkg::*;

    localparam int unsigned TEN_W = $clog2(HOLD_MAX + 1);
    localparam int unsigned GAP_W = $clog2(REL_GAP + 1);
    localparam int unsigned WD_W  = $clog2(WDOG + 1);

    logic             pending_c;
    logic             urgent_c;
    logic             sel_c;

    logic [1:0]       state_q,    state_d;
    logic             dbrl_0_q,   dbrl_0_d;
    logic             dbrl_1_q,   dbrl_1_d;
    logic             bus_own_q,  bus_own_d;
    logic             xfer_go_q,  xfer_go_d;
    logic             xfer_sel_q, xfer_sel_d;
    logic             dsp_done_q, dsp_done_d;
    logic             dma_done_q, dma_done_d;
    logic             wd_err_q,   wd_err_d;
    logic             outst_q,    outst_d;
    logic             preempt_q,  preempt_d;
    logic [TEN_W-1:0] tenure_q,   tenure_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [WD_W-1:0]  wd_cnt_q,   wd_cnt_d;

    logic             preempt_now;
    logic             done_now;
    logic             go_rel;

    busreq_prio u_prio (
        .dsp_req   (dsp_req),
        .dsp_hipri (dsp_hipri),
        .dma_req   (dma_req),
        .pending_c (pending_c),
        .urgent_c  (urgent_c),
        .sel_c     (sel_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        dbrl_0_d    = dbrl_0_q;
        dbrl_1_d    = dbrl_1_q;
        bus_own_d   = bus_own_q;
        xfer_go_d   = 1'b0;
        xfer_sel_d  = xfer_sel_q;
        dsp_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        wd_err_d    = wd_err_q;
        outst_d     = outst_q;
        preempt_d   = preempt_q;
        tenure_d    = tenure_q;
        gap_cnt_d   = gap_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        preempt_now = preempt_q | dbgl;
        done_now    = dsp_done_q | dma_done_q;
        go_rel      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                outst_d   = 1'b0;
                preempt_d = 1'b0;
                tenure_d  = '0;
                wd_cnt_d  = '0;
                if (pending_c) begin
                    state_d  = ST_REQ;
                    dbrl_0_d = 1'b0;
                    dbrl_1_d = ~urgent_c;
                end
            end

            ST_REQ: begin
                dbrl_1_d = ~urgent_c;
                if (!pending_c) begin
                    state_d  = ST_IDLE;
                    dbrl_0_d = 1'b1;
                    dbrl_1_d = 1'b1;
                    wd_cnt_d = '0;
                end else if (!dbgl) begin
                    state_d   = ST_OWN;
                    bus_own_d = 1'b1;
                    dbrl_1_d  = 1'b1;
                    wd_cnt_d  = '0;
                end else if (wd_cnt_q != WD_W'(WDOG)) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    if (wd_cnt_q == WD_W'(WDOG - 1)) begin
                        wd_err_d = 1'b1;
                    end
                end
            end

            ST_OWN: begin
                preempt_d = preempt_now;
                if (outst_q) begin
                    if (ack) begin
                        outst_d  = 1'b0;
                        tenure_d = tenure_q + TEN_W'(1);
                        if (xfer_sel_q == SEL_DMA) begin
                            dma_done_d = 1'b1;
                        end else begin
                            dsp_done_d = 1'b1;
                        end
                    end
                end else if (done_now) begin
                    // Requester has not yet reacted to done; only request-independent exits here
                    go_rel = preempt_now || (tenure_q == TEN_W'(HOLD_MAX));
                end else if (preempt_now || !pending_c || (tenure_q == TEN_W'(HOLD_MAX))) begin
                    go_rel = 1'b1;
                end else begin
                    xfer_go_d  = 1'b1;
                    xfer_sel_d = sel_c;
                    outst_d    = 1'b1;
                end
                if (go_rel) begin
                    state_d   = ST_REL;
                    dbrl_0_d  = 1'b1;
                    dbrl_1_d  = 1'b1;
                    bus_own_d = 1'b0;
                    gap_cnt_d = '0;
                    preempt_d = 1'b0;
                    tenure_d  = '0;
                end
            end

            ST_REL: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(REL_GAP - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q    <= ST_IDLE;
            dbrl_0_q   <= 1'b1;
            dbrl_1_q   <= 1'b1;
            bus_own_q  <= 1'b0;
            xfer_go_q  <= 1'b0;
            xfer_sel_q <= SEL_DSP;
            dsp_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            wd_err_q   <= 1'b0;
            outst_q    <= 1'b0;
            preempt_q  <= 1'b0;
            tenure_q   <= '0;
            gap_cnt_q  <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            dbrl_0_q   <= dbrl_0_d;
            dbrl_1_q   <= dbrl_1_d;
            bus_own_q  <= bus_own_d;
            xfer_go_q  <= xfer_go_d;
            xfer_sel_q <= xfer_sel_d;
            dsp_done_q <= dsp_done_d;
            dma_done_q <= dma_done_d;
            wd_err_q   <= wd_err_d;
            outst_q    <= outst_d;
            preempt_q  <= preempt_d;
            tenure_q   <= tenure_d;
            gap_cnt_q  <= gap_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign dbrl_0   = dbrl_0_q;
    assign dbrl_1   = dbrl_1_q;
    assign bus_own  = bus_own_q;
    assign xfer_go  = xfer_go_q;
    assign xfer_sel = xfer_sel_q;
    assign dsp_done = dsp_done_q;
    assign dma_done = dma_done_q;
    assign wd_err   = wd_err_q;

endmodule

// File: tb/tb_jerry_busreq.sv
// Directed bench for jerry_busreq: reset, single/dual requests, tenure limit,
// preemption and grant watchdog, with invariants monitored every cycle.
module tb_jerry_busreq;

    logic sys_clk;
    logic resetl;
    logic dsp_req;
    logic dsp_hipri;
    logic dma_req;
    logic dbgl;
    logic ack;
    logic dbrl_0;
    logic dbrl_1;
    logic bus_own;
    logic xfer_go;
    logic xfer_sel;
    logic dsp_done;
    logic dma_done;
    logic wd_err;

    int checks;
    int errors;
    int go_cnt;
    int dsp_cnt;
    int dma_cnt;
    int inv_bad;
    int base_go;
    int base_dsp;
    int base_dma;
    int gos;
    int dones;
    int ack_dly;
    bit owned;
    bit rel_seen;

    jerry_busreq dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .dsp_req   (dsp_req),
        .dsp_hipri (dsp_hipri),
        .dma_req   (dma_req),
        .dbgl      (dbgl),
        .ack       (ack),
        .dbrl_0    (dbrl_0),
        .dbrl_1    (dbrl_1),
        .bus_own   (bus_own),
        .xfer_go   (xfer_go),
        .xfer_sel  (xfer_sel),
        .dsp_done  (dsp_done),
        .dma_done  (dma_done),
        .wd_err    (wd_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counters and invariants, sampled mid-cycle
    initial begin
        go_cnt = 0; dsp_cnt = 0; dma_cnt = 0; inv_bad = 0;
    end
    always @(negedge sys_clk) begin
        if (xfer_go)  go_cnt++;
        if (dsp_done) dsp_cnt++;
        if (dma_done) dma_cnt++;
        if ((!dbrl_1 && dbrl_0) || (bus_own && dbrl_0)) inv_bad++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dbrl_v();
        return 32'({dbrl_1, dbrl_0});
    endfunction

    initial begin
        checks = 0; errors = 0;
        resetl = 1'b0; dsp_req = 1'b0; dsp_hipri = 1'b0; dma_req = 1'b0;
        dbgl = 1'b1; ack = 1'b0;
        step(); step();
        chk("reset_outputs", 32'({dbrl_1, dbrl_0, bus_own, xfer_go, xfer_sel, dsp_done, dma_done, wd_err}), 'b11000000);
        resetl = 1'b1;
        step();
        chk("idle_quiet", dbrl_v(), 'b11);

        // Single DSP request, grant three cycles later
        dsp_req = 1'b1;
        step();
        chk("dsp_req_dbrl", dbrl_v(), 'b10);
        step(); step();
        chk("dsp_wait_dbrl", dbrl_v(), 'b10);
        chk("dsp_wait_own", 32'(bus_own), 0);
        dbgl = 1'b0;
        step();
        chk("dsp_grant_own", 32'(bus_own), 1);
        chk("dsp_grant_dbrl", dbrl_v(), 'b10);
        step();
        chk("dsp_go", 32'({xfer_go, xfer_sel}), 'b10);
        step();
        chk("dsp_go_single", 32'(xfer_go), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("dsp_done_pulse", 32'({dsp_done, dma_done}), 'b10);
        dsp_req = 1'b0;
        step();
        chk("dsp_done_end", 32'({dsp_done, bus_own}), 'b01);
        step();
        chk("dsp_rel_dbrl", dbrl_v(), 'b11);
        chk("dsp_rel_own", 32'(bus_own), 0);
        dbgl = 1'b1;
        step();
        chk("dsp_rel_gap", dbrl_v(), 'b11);
        step();

        // Reset while a DMA transfer is outstanding
        dma_req = 1'b1;
        step();
        chk("rst_req_dbrl", dbrl_v(), 'b00);
        dbgl = 1'b0;
        step();
        chk("rst_grant_dbrl", dbrl_v(), 'b10);
        step();
        chk("rst_go_dma", 32'({xfer_go, xfer_sel}), 'b11);
        step();
        resetl = 1'b0;
        step();
        resetl = 1'b1; dma_req = 1'b0; dbgl = 1'b1;
        chk("rst_mid_dbrl", dbrl_v(), 'b11);
        chk("rst_mid_own", 32'({bus_own, xfer_go, xfer_sel}), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rst_stale_ack", 32'({dsp_done, dma_done}), 0);
        step();
        chk("rst_stale_ack2", 32'({dsp_done, dma_done, dbrl_1, dbrl_0}), 'b0011);

        // Both requests pending: DMA first, then DSP
        base_go = go_cnt; base_dsp = dsp_cnt; base_dma = dma_cnt;
        dma_req = 1'b1; dsp_req = 1'b1;
        step();
        chk("both_dbrl", dbrl_v(), 'b00);
        dbgl = 1'b0;
        step();
        chk("both_grant", 32'({bus_own, dbrl_1, dbrl_0}), 'b110);
        step();
        chk("both_go1", 32'({xfer_go, xfer_sel}), 'b11);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("both_done1", 32'({dma_done, dsp_done}), 'b10);
        dma_req = 1'b0;
        step();
        chk("both_gap_nogo", 32'(xfer_go), 0);
        step();
        chk("both_go2", 32'({xfer_go, xfer_sel}), 'b10);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("both_done2", 32'({dma_done, dsp_done}), 'b01);
        dsp_req = 1'b0;
        step(); step();
        chk("both_rel", 32'({bus_own, dbrl_1, dbrl_0}), 'b011);
        dbgl = 1'b1;
        step(); step();
        chk("both_go_count", 32'(go_cnt - base_go), 2);
        chk("both_done_count", 32'({dma_cnt - base_dma, dsp_cnt - base_dsp}), 32'({32'd1, 32'd1}));

        // Preemption after xfer_go; request kept held through REL
        base_go = go_cnt;
        dsp_req = 1'b1; dsp_hipri = 1'b1;
        step();
        chk("pre_req_dbrl", dbrl_v(), 'b00);
        dbgl = 1'b0;
        step();
        step();
        chk("pre_go", 32'({xfer_go, xfer_sel}), 'b10);
        dbgl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pre_wait", 32'({xfer_go, bus_own}), 'b01);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("pre_done", 32'({dsp_done, bus_own, dbrl_0}), 'b110);
        step();
        chk("pre_rel", 32'({bus_own, dbrl_1, dbrl_0}), 'b011);
        step();
        chk("pre_gap1", dbrl_v(), 'b11);
        step();
        chk("pre_gap2", dbrl_v(), 'b11);
        step();
        chk("pre_rereq", dbrl_v(), 'b00);
        dsp_req = 1'b0; dsp_hipri = 1'b0;
        step();
        chk("pre_drop_idle", dbrl_v(), 'b11);
        chk("pre_go_count", 32'(go_cnt - base_go), 1);

        // Tenure limit: DSP keeps requesting, bus granted throughout
        dsp_req = 1'b1; dbgl = 1'b0;
        gos = 0; dones = 0; ack_dly = 0; owned = 1'b0; rel_seen = 1'b0;
        for (int c = 0; c < 300 && !rel_seen; c++) begin
            step();
            if (xfer_go) begin gos++; ack_dly = 2; end
            if (dsp_done) dones++;
            if (bus_own) owned = 1'b1;
            else if (owned) rel_seen = 1'b1;
            ack = 1'b0;
            if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) ack = 1'b1;
            end
        end
        ack = 1'b0;
        chk("hold_released", 32'(rel_seen), 1);
        chk("hold_dones", 32'(dones), 8);
        chk("hold_gos", 32'(gos), 8);
        chk("hold_rel_dbrl", dbrl_v(), 'b11);
        step();
        chk("hold_gap1", dbrl_v(), 'b11);
        step();
        chk("hold_gap2", dbrl_v(), 'b11);
        step();
        chk("hold_rereq", dbrl_v(), 'b10);
        step();
        chk("hold_regrant", 32'(bus_own), 1);
        dsp_req = 1'b0;
        step();
        chk("hold_drop_rel", 32'({bus_own, dbrl_1, dbrl_0}), 'b011);
        dbgl = 1'b1;
        step(); step();

        // Grant watchdog
        dsp_req = 1'b1;
        step();
        chk("wd_start", 32'({wd_err, dbrl_1, dbrl_0}), 'b010);
        repeat (1022) step();
        chk("wd_before", 32'(wd_err), 0);
        step();
        chk("wd_set", 32'({wd_err, dbrl_1, dbrl_0}), 'b110);
        repeat (5) step();
        chk("wd_sticky_req", 32'({wd_err, dbrl_1, dbrl_0}), 'b110);
        dbgl = 1'b0;
        step();
        chk("wd_grant", 32'({wd_err, bus_own}), 'b11);
        step();
        chk("wd_go", 32'(xfer_go), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("wd_done", 32'(dsp_done), 1);
        dsp_req = 1'b0;
        step(); step();
        chk("wd_after_rel", 32'({wd_err, bus_own, dbrl_1, dbrl_0}), 'b1011);
        dbgl = 1'b1;
        step(); step();

        chk("invariants", 32'(inv_bad), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
